// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the parallel-in / serial-out serializer.
//   state_e   : FSM encoding (IDLE waits for a word, SHIFT streams it out)
//   DEFAULT_N : default word width
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_N = 8;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer, MSB first, with a valid/ready load port.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   pin        - N-bit word offered for loading
//   load_valid - pin holds a word
//   load_ready - word is accepted on this edge if load_valid is also high
//   sout       - serial bit (0 when sout_valid is low)
//   sout_valid - sout is live
//   done       - pulses with bit 0 of each word
//   busy       - a word is being shifted out
// A new word may be taken on the edge that retires bit 0 of the current word,
// so back-to-back words stream with no idle cycle between them.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pin,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         done,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e         state_q;
  logic [N-1:0]   sreg_q;
  logic [CW-1:0]  cnt_q;

  logic shifting, last, handshake;

  assign shifting  = (state_q == SHIFT);
  assign last      = shifting && (cnt_q == LAST);
  assign handshake = load_valid && load_ready;

  // Outputs are pure decodes of registered state; sreg_q[N-1] is always the
  // bit being presented, so no separate output flops are needed.
  assign load_ready = !shifting || last;
  assign sout_valid = shifting;
  assign busy       = shifting;
  assign sout       = shifting & sreg_q[N-1];
  assign done       = last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else if (handshake) begin
      // Covers both IDLE->SHIFT and the last-bit reload (SHIFT->SHIFT).
      state_q <= SHIFT;
      sreg_q  <= pin;
      cnt_q   <= '0;
    end else if (shifting) begin
      if (last) begin
        state_q <= IDLE;
        sreg_q  <= '0;
        cnt_q   <= '0;
      end else begin
        sreg_q <= {sreg_q[N-2:0], 1'b0};
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (N=8): reference model is a queue of
// pending {bit,last} pairs, plus a table of single-word vectors, hand-written
// corner sequences and a randomized phase.
module tb_piso_serializer;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pin;
  logic         load_valid;
  logic         load_ready, sout, sout_valid, done, busy;

  always #5 clk = ~clk;

  piso_serializer #(.N(N)) dut (
    .clk(clk), .rst(rst), .pin(pin), .load_valid(load_valid),
    .load_ready(load_ready), .sout(sout), .sout_valid(sout_valid),
    .done(done), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bits still to be emitted, front = bit on sout now.
  bit mq[$];
  bit ml[$];
  bit m_rdy;
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      ml.delete();
    end else begin
      m_rdy = (mq.size() <= 1);
      if (mq.size() > 0) begin
        void'(mq.pop_front());
        void'(ml.pop_front());
      end
      if (load_valid && m_rdy)
        for (int i = N - 1; i >= 0; i--) begin
          mq.push_back(pin[i]);
          ml.push_back(i == 0);
        end
    end
  end

  // Per-cycle comparison of every output against the model.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    logic ev, es, ed, er;
    if (chk_en) begin
      ev = (mq.size() > 0);
      es = ev ? mq[0] : 1'b0;
      ed = ev ? ml[0] : 1'b0;
      er = (mq.size() <= 1);
      chk("model", {27'd0, load_ready, sout, sout_valid, done, busy},
                   {27'd0, er, es, ev, ed, ev});
    end
  end

  // Downstream shift-left SIPO.
  logic [N-1:0] sipo = '0;
  always @(posedge clk) if (sout_valid) sipo <= {sipo[N-2:0], sout};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [N-1:0] w);
    pin = w; load_valid = 1'b1;
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic expect_bits(input string nm, input logic [N-1:0] bits);
    for (int i = N - 1; i >= 0; i--) begin
      chk({nm, ".valid"}, sout_valid, 1);
      chk({nm, ".sout"},  sout, bits[i]);
      chk({nm, ".done"},  done, (i == 0));
      cyc();
    end
  endtask

  task automatic expect_idle(input string nm);
    chk({nm, ".idle"}, {load_ready, sout, sout_valid, done, busy}, 5'b10000);
  endtask

  // Two words back to back with load_valid held high throughout.
  task automatic b2b(input string nm, input logic [N-1:0] a, input logic [N-1:0] b);
    pin = a; load_valid = 1'b1;
    cyc();
    pin = b;
    for (int i = N - 1; i >= 0; i--) begin
      chk({nm, ".rdy"},  load_ready, (i == 0));
      chk({nm, ".sout"}, sout, a[i]);
      chk({nm, ".done"}, done, (i == 0));
      cyc();
    end
    load_valid = 1'b0;
    chk({nm, ".sipo1"}, sipo, a);
    expect_bits({nm, ".w2"}, b);
    chk({nm, ".sipo2"}, sipo, b);
    expect_idle(nm);
  endtask

  typedef struct {
    logic [N-1:0] w;
    logic [N-1:0] bits;  // expected serial stream, first bit on the left
  } vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{8'b10110101, 8'b10110101};
    vt[1] = '{8'h81,       8'b10000001};
    vt[2] = '{8'h00,       8'b00000000};
    vt[3] = '{8'hFF,       8'b11111111};
    vt[4] = '{8'h3C,       8'b00111100};
    vt[5] = '{8'hC3,       8'b11000011};
    vt[6] = '{8'h01,       8'b00000001};
    vt[7] = '{8'h80,       8'b10000000};

    rst = 1'b1; load_valid = 1'b0; pin = '0;
    cyc();
    cyc();
    chk("reset", {load_ready, sout, sout_valid, done, busy}, 5'b10000);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single words from IDLE.
    foreach (vt[k]) begin
      load_word(vt[k].w);
      expect_bits($sformatf("vec%0d", k), vt[k].bits);
      expect_idle($sformatf("vec%0d", k));
      chk($sformatf("vec%0d.sipo", k), sipo, vt[k].w);
    end

    // Back-to-back words.
    b2b("b2b", 8'b10110101, 8'b01010011);
    b2b("sipo", 8'h3C, 8'hC3);

    // Input noise while not ready must not disturb the word in flight.
    pin = 8'hB5; load_valid = 1'b1;
    cyc();
    for (int i = N - 1; i >= 0; i--) begin
      chk("noise.sout", sout, N'(8'hB5) >> i & 1);
      pin = N'($urandom);
      load_valid = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      cyc();
    end
    load_valid = 1'b0;
    expect_idle("noise");
    chk("noise.sipo", sipo, 8'hB5);

    // Reset mid-word aborts it.
    load_word(8'hFF);
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    expect_idle("midrst");
    cyc();
    expect_idle("midrst2");
    load_word(8'h81);
    expect_bits("after_rst", 8'b10000001);
    expect_idle("after_rst");

    // Reset wins over a simultaneous handshake.
    pin = 8'hA5; load_valid = 1'b1; rst = 1'b1;
    cyc();
    rst = 1'b0; load_valid = 1'b0;
    expect_idle("rst_hs");
    cyc();
    expect_idle("rst_hs2");

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 600; c++) begin
      pin = N'($urandom);
      load_valid = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 60) == 0);
      cyc();
    end
    rst = 1'b0; load_valid = 1'b0;
    for (int c = 0; c < 2 * N; c++) cyc();
    expect_idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter N, default 8, meaning word width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port pin, input, N, parallel word to serialize.
REQ-005 SHALL have port load_valid, input, 1, pin holds a word offered for loading.
REQ-006 SHALL have port load_ready, output, 1, block accepts pin this cycle.
REQ-007 SHALL have port sout, output, 1, serial data bit.
REQ-008 SHALL have port sout_valid, output, 1, sout carries a live bit this cycle.
REQ-009 SHALL have port done, output, 1, one-cycle pulse coincident with the last bit (bit 0) of a word.
REQ-010 SHALL have port busy, output, 1, a word is being shifted out.

Function
REQ-011 SHALL implement FSM states IDLE and SHIFT.
REQ-012 Load handshake SHALL complete on a rising clk edge where load_valid=1 and load_ready=1; pin is captured into an internal N-bit shift register at that edge.
REQ-013 load_ready SHALL be 1 in IDLE, and 1 in SHIFT only while the bit counter holds N-1 (last bit); 0 otherwise.
REQ-014 IDLE -> SHIFT on a completed handshake; SHIFT -> IDLE after bit 0 is presented and no handshake completes on that edge; SHIFT -> SHIFT (new word) when a handshake completes on the last-bit edge.
REQ-015 Serialization SHALL be MSB-first: the cycle after capture, sout = pin[N-1]; each following cycle presents the next lower bit; bit 0 appears N-1 cycles after bit N-1.
REQ-016 Latency SHALL be 1 cycle from handshake edge to first bit; a word occupies exactly N consecutive sout_valid cycles.
REQ-017 Back-to-back words (handshake on the last-bit edge) SHALL produce 2N consecutive sout_valid cycles with no gap.
REQ-018 sout_valid and busy SHALL be 1 exactly in SHIFT; sout SHALL be 0 whenever sout_valid=0.
REQ-019 Bit counter SHALL be $clog2(N) bits wide, count 0..N-1, reset to 0 on each capture, and never wrap past N-1 within a word.
REQ-020 done SHALL be 1 only in the cycle sout_valid=1 with counter = N-1.
REQ-021 load_valid with load_ready=0 SHALL be ignored (no capture, no state change); pin changes during SHIFT SHALL NOT affect the word in flight.
REQ-022 The serial stream fed into an N-bit shift-left SIPO sampling on sout_valid SHALL reproduce pin exactly after N bits.

Reset
REQ-023 When rst=1 at a clk edge: state=IDLE, shift register=0, counter=0, sout=0, sout_valid=0, done=0, busy=0; load_ready=1 from the following cycle.
REQ-024 rst SHALL take priority over a simultaneous handshake; the offered word is discarded.
REQ-025 rst asserted mid-word SHALL abort the word immediately; no further bits of it are emitted.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, SHIFT) and the default width constant 8.
REQ-027 The design SHALL be a single module with no sub-modules; counter and shift register are inline.

Verification
REQ-028 Reset, then load 8'b10110101 in IDLE -> from next cycle sout = 1,0,1,1,0,1,0,1 with sout_valid=1 for 8 cycles, done on the 8th, then IDLE.
REQ-029 Load 8'b10110101, hold load_valid=1 with 8'b01010011 -> load_ready=1 only on the last-bit cycle; 16 gapless bits 10110101 01010011; done twice.
REQ-030 Toggle pin and load_valid during SHIFT with load_ready=0 -> the in-flight word is unchanged and no extra capture occurs.
REQ-031 Assert rst for 1 cycle after 3 bits of 8'hFF -> sout_valid=0, sout=0, done never pulses; next load of 8'h81 emits 1,0,0,0,0,0,0,1.
REQ-032 Assert rst on the same edge as a handshake of 8'hA5 -> no bits emitted; block idle with load_ready=1.
REQ-033 Connect sout/sout_valid to an 8-bit SIPO; stream 8'h3C then 8'hC3 -> SIPO output equals 8'h3C after 8 bits and 8'hC3 after 16.
